opb_reg_bank_arbiter: RTL and testbench



---
 rtl/opb_arb_pkg.sv | 11 +
 rtl/opb_resp_mux.sv | 43 ++++
 rtl/opb_reg_bank_arbiter.sv | 142 ++++++++++++++
 tb/tb_opb_reg_bank_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/opb_arb_pkg.sv
// Shared types and constants for the OPB register-bank arbiter.
package opb_arb_pkg;

   typedef enum logic [1:0] {StIdle, StWait, StRecover} opb_state_e;

   localparam int unsigned OPB_WIN_SHIFT = 8;
   localparam int unsigned OPB_DWIDTH    = 32;
   // Up to 16 windows, so a 4-bit window index.
   localparam int unsigned IDX_W         = 4;

endpackage

// File: rtl/opb_resp_mux.sv
// Selects the addressed slave's response and read data; everything is forced low unless active.
module opb_resp_mux
   import opb_arb_pkg::*;
#(
   parameter int unsigned NumSlaves = 8,
   parameter int unsigned DWidth    = OPB_DWIDTH
) (
   input  logic                           active,
   input  logic                           rnw,
   input  logic [IDX_W-1:0]               idx,
   input  logic [NumSlaves*DWidth-1:0]    dbus_in,
   input  logic [NumSlaves-1:0]           xferack_in,
   input  logic [NumSlaves-1:0]           errack_in,
   input  logic [NumSlaves-1:0]           retry_in,
   input  logic [NumSlaves-1:0]           toutsup_in,
   output logic                           xferack,
   output logic                           errack,
   output logic                           retry,
   output logic                           toutsup,
   output logic [DWidth-1:0]              dbus
);

   always_comb begin
      xferack = 1'b0;
      errack  = 1'b0;
      retry   = 1'b0;
      toutsup = 1'b0;
      dbus    = '0;
      for (int k = 0; k < int'(NumSlaves); k++) begin
         if (active && (idx == IDX_W'(k))) begin
            xferack = xferack_in[k];
            errack  = errack_in[k];
            retry   = retry_in[k];
            toutsup = toutsup_in[k];
            // OR-bus: data only on an acknowledged read.
            if (rnw && xferack_in[k]) begin
               dbus = dbus_in[k*DWidth +: DWidth];
            end
         end
      end
   end

endmodule

// File: rtl/opb_reg_bank_arbiter.sv
// Decodes OPB addresses into 256-byte slave windows, forwards the selected slave's response
// and raises errAck when the slave stays silent too long.
module opb_reg_bank_arbiter
   import opb_arb_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01040000,
   parameter int unsigned C_NUM_SLAVES = 8,
   parameter int unsigned C_TIMEOUT    = 16,
   parameter int unsigned C_OPB_DWIDTH = OPB_DWIDTH
) (
   input  logic                                OPB_Clk,
   input  logic                                OPB_Rst_n,
   input  logic [0:31]                         OPB_ABus,
   input  logic                                OPB_RNW,
   input  logic                                OPB_select,
   input  logic                                OPB_seqAddr,
   output logic [C_NUM_SLAVES-1:0]             sl_select,
   input  logic [C_NUM_SLAVES*C_OPB_DWIDTH-1:0] sl_dbus_in,
   input  logic [C_NUM_SLAVES-1:0]             sl_xferack_in,
   input  logic [C_NUM_SLAVES-1:0]             sl_errack_in,
   input  logic [C_NUM_SLAVES-1:0]             sl_retry_in,
   input  logic [C_NUM_SLAVES-1:0]             sl_toutsup_in,
   output logic [0:C_OPB_DWIDTH-1]             Sl_DBus,
   output logic                                Sl_xferAck,
   output logic                                Sl_errAck,
   output logic                                Sl_retry,
   output logic                                Sl_toutSup,
   output logic [15:0]                         timeout_count
);

   localparam logic [31:0] WIN_LIMIT = 32'(C_NUM_SLAVES << OPB_WIN_SHIFT);
   localparam logic [7:0]  TOUT_LAST = 8'(C_TIMEOUT - 1);

   opb_state_e                state_q, state_d;
   logic [C_NUM_SLAVES-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [7:0]                tcnt_q, tcnt_d;
   logic [15:0]               tcount_q, tcount_d;

   logic [31:0]               offset;
   logic [IDX_W-1:0]          win_idx;
   logic                      hit;
   logic                      tout_err;
   logic                      mux_xferack, mux_errack, mux_retry, mux_toutsup;
   logic [C_OPB_DWIDTH-1:0]   mux_dbus;
   logic                      slave_resp;
   logic                      unused_seq_addr;

   assign unused_seq_addr = OPB_seqAddr;

   // Unsigned subtraction wraps addresses below the base into a miss.
   assign offset  = OPB_ABus - C_BASEADDR;
   assign win_idx = offset[OPB_WIN_SHIFT +: IDX_W];
   assign hit     = OPB_select && (offset < WIN_LIMIT);

   opb_resp_mux #(
      .NumSlaves (C_NUM_SLAVES),
      .DWidth    (C_OPB_DWIDTH)
   ) u_resp_mux (
      .active     (state_q == StWait),
      .rnw        (OPB_RNW),
      .idx        (idx_q),
      .dbus_in    (sl_dbus_in),
      .xferack_in (sl_xferack_in),
      .errack_in  (sl_errack_in),
      .retry_in   (sl_retry_in),
      .toutsup_in (sl_toutsup_in),
      .xferack    (mux_xferack),
      .errack     (mux_errack),
      .retry      (mux_retry),
      .toutsup    (mux_toutsup),
      .dbus       (mux_dbus)
   );

   assign slave_resp = mux_xferack | mux_errack | mux_retry;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      idx_d    = idx_q;
      tcnt_d   = tcnt_q;
      tcount_d = tcount_q;
      tout_err = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hit) begin
               idx_d  = win_idx;
               tcnt_d = '0;
               for (int k = 0; k < int'(C_NUM_SLAVES); k++) begin
                  sel_d[k] = (win_idx == IDX_W'(k));
               end
               state_d = StWait;
            end
         end
         StWait: begin
            if (!OPB_select) begin
               sel_d   = '0;
               state_d = StIdle;
            end else if (slave_resp) begin
               sel_d   = '0;
               state_d = StRecover;
            end else if (!mux_toutsup) begin
               if (tcnt_q == TOUT_LAST) begin
                  tout_err = 1'b1;
                  sel_d    = '0;
                  state_d  = StRecover;
                  if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         StRecover: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         idx_q    <= '0;
         tcnt_q   <= '0;
         tcount_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         idx_q    <= idx_d;
         tcnt_q   <= tcnt_d;
         tcount_q <= tcount_d;
      end
   end

   assign sl_select     = sel_q;
   assign Sl_DBus       = mux_dbus;
   assign Sl_xferAck    = mux_xferack;
   assign Sl_errAck     = mux_errack | tout_err;
   assign Sl_retry      = mux_retry;
   assign Sl_toutSup    = mux_toutsup;
   assign timeout_count = tcount_q;

endmodule

// File: tb/tb_opb_reg_bank_arbiter.sv
// Randomized bench for opb_reg_bank_arbiter against a transaction-level reference model.
module tb_opb_reg_bank_arbiter;

   localparam logic [31:0] BASE = 32'h01040000;
   localparam int          N    = 8;
   localparam int          T    = 16;
   localparam int          DW   = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [0:31]       abus = '0;
   logic              rnw = 1'b0;
   logic              opb_select = 1'b0;
   logic              seq_addr = 1'b0;
   logic [N-1:0]      sl_select;
   logic [N*DW-1:0]   sl_dbus_in = '0;
   logic [N-1:0]      sl_xferack_in = '0;
   logic [N-1:0]      sl_errack_in = '0;
   logic [N-1:0]      sl_retry_in = '0;
   logic [N-1:0]      sl_toutsup_in = '0;
   logic [0:DW-1]     dbus;
   logic              xferack, errack, retry, toutsup;
   logic [15:0]       timeout_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_tcount = 0;

   always #5 clk = ~clk;

   opb_reg_bank_arbiter #(
      .C_BASEADDR   (BASE),
      .C_NUM_SLAVES (N),
      .C_TIMEOUT    (T),
      .C_OPB_DWIDTH (DW)
   ) dut (
      .OPB_Clk       (clk),
      .OPB_Rst_n     (rst_n),
      .OPB_ABus      (abus),
      .OPB_RNW       (rnw),
      .OPB_select    (opb_select),
      .OPB_seqAddr   (seq_addr),
      .sl_select     (sl_select),
      .sl_dbus_in    (sl_dbus_in),
      .sl_xferack_in (sl_xferack_in),
      .sl_errack_in  (sl_errack_in),
      .sl_retry_in   (sl_retry_in),
      .sl_toutsup_in (sl_toutsup_in),
      .Sl_DBus       (dbus),
      .Sl_xferAck    (xferack),
      .Sl_errAck     (errack),
      .Sl_retry      (retry),
      .Sl_toutSup    (toutsup),
      .timeout_count (timeout_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outs(input logic [N-1:0] e_sel, input bit e_xa, input bit e_ea,
                             input bit e_ra, input bit e_ts, input logic [31:0] e_d);
      check("sl_select", 32'(sl_select), 32'(e_sel));
      check("xferAck",   32'(xferack),   32'(e_xa));
      check("errAck",    32'(errack),    32'(e_ea));
      check("retry",     32'(retry),     32'(e_ra));
      check("toutSup",   32'(toutsup),   32'(e_ts));
      check("DBus",      32'(dbus),      e_d);
   endtask

   // Random noise on every slave; when in_wait, the target slave gets the given response.
   task automatic drive_slaves(input bit in_wait, input int tgt, input bit xa, input bit ea,
                               input bit ra, input bit ts, input logic [31:0] data);
      sl_xferack_in = N'($urandom);
      sl_errack_in  = N'($urandom);
      sl_retry_in   = N'($urandom);
      sl_toutsup_in = N'($urandom);
      for (int k = 0; k < N; k++) sl_dbus_in[k*DW +: DW] = $urandom;
      if (in_wait) begin
         sl_xferack_in[tgt] = xa;
         sl_errack_in[tgt]  = ea;
         sl_retry_in[tgt]   = ra;
         sl_toutsup_in[tgt] = ts;
         sl_dbus_in[tgt*DW +: DW] = data;
      end
   endtask

   // kind: 0 xferAck, 1 errAck, 2 retry, 3 silent. delay = WAIT cycle of the response.
   // tsup_len = leading WAIT cycles with toutSup; abort_at = WAIT cycle where select drops (0 none).
   task automatic run_txn(input logic [31:0] addr, input bit rd, input int kind, input int delay,
                          input int tsup_len, input int abort_at, input logic [31:0] data);
      logic [31:0]  off;
      logic [N-1:0] oh;
      bit           hit, resp_end, xa, ea, ra, ts, s_ea;
      int           idx, tout_w, e;
      off = addr - BASE;
      hit = off < 32'(N * 256);
      idx = int'(off >> 8);
      @(negedge clk);
      abus = addr;
      rnw = rd;
      opb_select = 1'b1;
      drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (!hit) begin
         repeat (40) begin
            @(negedge clk);
            drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         end
         @(negedge clk);
         opb_select = 1'b0;
         #1 check("tcount_miss", 32'(timeout_count), 32'(exp_tcount));
         return;
      end
      oh = N'(1) << idx;
      // Suppressed cycles do not advance the timeout, so the deadline slides by tsup_len.
      tout_w   = T + tsup_len;
      resp_end = (kind != 3) && (delay <= tout_w);
      e        = resp_end ? delay : tout_w;
      for (int w = 1; w <= e; w++) begin
         @(negedge clk);
         if (w == abort_at) begin
            opb_select = 1'b0;
            drive_slaves(1'b1, idx, 1'b0, 1'b0, 1'b0, 1'b0, data);
            #1 check_outs(oh, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("tcount_abort", 32'(timeout_count), 32'(exp_tcount));
            return;
         end
         xa   = resp_end && (w == e) && (kind == 0);
         s_ea = resp_end && (w == e) && (kind == 1);
         ra   = resp_end && (w == e) && (kind == 2);
         ea   = s_ea || (!resp_end && (w == e));
         ts   = (w <= tsup_len);
         drive_slaves(1'b1, idx, xa, s_ea, ra, ts, data);
         #1 check_outs(oh, xa, ea, ra, ts, (rd && xa) ? data : 32'h0);
      end
      if (!resp_end && exp_tcount < 65535) exp_tcount++;
      @(negedge clk);
      opb_select = 1'b0;
      drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("tcount", 32'(timeout_count), 32'(exp_tcount));
   endtask

   initial begin
      logic [31:0] addr;
      int kind, delay, tsup_len, abort_at, r;

      #3 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("tcount_reset", 32'(timeout_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn(32'h01040204, 1'b1, 0, 3,  0,  0, 32'hDEADBEEF);
      run_txn(32'h010407FC, 1'b0, 0, 2,  0,  0, 32'h12345678);
      run_txn(32'h01040800, 1'b1, 0, 1,  0,  0, 32'h0);
      run_txn(32'h0103FFFC, 1'b1, 0, 1,  0,  0, 32'h0);
      run_txn(32'h01040100, 1'b1, 3, 0,  0,  0, 32'hA5A5A5A5);
      run_txn(32'h01040100, 1'b1, 0, 31, 30, 0, 32'hCAFEF00D);
      run_txn(32'h01040104, 1'b1, 3, 0,  0,  6, 32'h0BADF00D);
      // Response lands on the timeout cycle: the response must win.
      run_txn(32'h01040500, 1'b1, 0, T,  0,  0, 32'h55AA55AA);
      run_txn(32'h01040600, 1'b0, 2, T,  0,  0, 32'h0);
      run_txn(32'h01040300, 1'b1, 1, 4,  0,  0, 32'h11111111);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            if ($urandom_range(0, 1) == 1) addr = BASE + 32'(N * 256) + $urandom_range(0, 4095);
            else                           addr = BASE - 32'd1 - $urandom_range(0, 255);
         end else begin
            addr = BASE + 32'($urandom_range(0, N - 1) * 256) + $urandom_range(0, 255);
         end
         kind     = $urandom_range(0, 3);
         delay    = $urandom_range(1, 24);
         tsup_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
         abort_at = 0;
         if ($urandom_range(0, 7) == 0) begin
            kind     = 3;
            tsup_len = 0;
            abort_at = $urandom_range(2, T - 1);
         end
         run_txn(addr, 1'($urandom_range(0, 1)), kind, delay, tsup_len, abort_at, $urandom);
      end

      // Asynchronous reset in the middle of a WAIT.
      @(negedge clk);
      abus = 32'h01040300;
      rnw = 1'b1;
      opb_select = 1'b1;
      drive_slaves(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) begin
         @(negedge clk);
         drive_slaves(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         #1 check("sel_pre_reset", 32'(sl_select), 32'h08);
      end
      #2 rst_n = 1'b0;
      exp_tcount = 0;
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("tcount_midreset", 32'(timeout_count), 32'(exp_tcount));
      @(negedge clk);
      opb_select = 1'b0;
      rst_n = 1'b1;
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #1 check_outs('0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      run_txn(32'h01040004, 1'b1, 0, 2, 0, 0, 32'hFEEDFACE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
